// File: rtl/agc_multistep.sv
// Multi-step automatic gain controller: measures peak-to-peak amplitude over windows of
// valid ADC samples and steps the relay gain index up/down, with overload and manual override.
module agc_multistep #(
  parameter int                        DATA_W         = 12,
  parameter int                        N_GAIN         = 4,
  parameter int                        IDX_W          = (N_GAIN > 1) ? $clog2(N_GAIN) : 1,
  parameter int                        CTRL_W         = 2,
  parameter logic [N_GAIN*CTRL_W-1:0]  GAIN_MAP       = {2'd3, 2'd2, 2'd1, 2'd0},
  parameter logic [N_GAIN*DATA_W-1:0]  LOWER_TH       = {12'd1798, 12'd1791, 12'd1791, 12'd1791},
  parameter logic [N_GAIN*DATA_W-1:0]  UPPER_TH       = {12'd3883, 12'd3723, 12'd3883, 12'd3685},
  parameter int                        OVER_TH        = 3941,
  parameter int                        WINDOW         = 512,
  parameter int                        SETTLE_CYCLES  = 10,
  parameter int                        STABLE_WINDOWS = 3,
  parameter int                        INIT_IDX       = 0
) (
  input  logic              adc_clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              manual_en,
  input  logic [IDX_W-1:0]  manual_idx,
  output logic [CTRL_W-1:0] gain_ctrl,
  output logic [IDX_W-1:0]  gain_idx,
  output logic              stable,
  output logic [DATA_W-1:0] pp_value,
  output logic              pp_valid,
  output logic              overload
);

  localparam int CNT_W = $clog2(WINDOW + 1);
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int STB_W = $clog2(STABLE_WINDOWS + 1);

  localparam logic [IDX_W-1:0]  MAX_IDX  = IDX_W'(N_GAIN - 1);
  localparam logic [IDX_W:0]    MAX_EXT  = (IDX_W + 1)'(N_GAIN - 1);
  localparam logic [IDX_W-1:0]  RST_IDX  = IDX_W'(INIT_IDX);
  localparam logic [DATA_W-1:0] OVER_LVL = DATA_W'(OVER_TH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WINDOW - 1);
  localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [STB_W-1:0]  STB_MAX  = STB_W'(STABLE_WINDOWS);

  typedef enum logic [1:0] {ST_SAMPLE, ST_CALC, ST_EVAL, ST_SETTLE} state_t;

  state_t            state;
  logic [DATA_W-1:0] acc_max, acc_min;
  logic [CNT_W-1:0]  acc_cnt;
  logic [SET_W-1:0]  settle_cnt;
  logic [STB_W-1:0]  stable_cnt;
  logic              manual_q;

  logic [IDX_W-1:0]  manual_clamped;
  logic [IDX_W-1:0]  eval_target;
  logic              eval_out_of_range;
  logic [DATA_W-1:0] lower_th, upper_th;
  logic [IDX_W:0]    idx_ext;

  function automatic logic [CTRL_W-1:0] map_ctrl(input logic [IDX_W-1:0] idx);
    return GAIN_MAP[int'(idx)*CTRL_W +: CTRL_W];
  endfunction

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    manual_clamped    = (manual_idx > MAX_IDX) ? MAX_IDX : manual_idx;
    lower_th          = LOWER_TH[int'(gain_idx)*DATA_W +: DATA_W];
    upper_th          = UPPER_TH[int'(gain_idx)*DATA_W +: DATA_W];
    idx_ext           = {1'b0, gain_idx};
    eval_target       = gain_idx;
    eval_out_of_range = 1'b1;
    if (pp_value > upper_th) begin
      eval_target = (gain_idx == '0) ? '0 : gain_idx - 1'b1;
    end else if (pp_value < (lower_th >> 2)) begin
      // Far too quiet: coarse two-step jump, clamped at the top of the table.
      eval_target = (idx_ext + (IDX_W + 1)'(2) > MAX_EXT) ? MAX_IDX : gain_idx + IDX_W'(2);
    end else if (pp_value < lower_th) begin
      eval_target = (gain_idx == MAX_IDX) ? MAX_IDX : gain_idx + 1'b1;
    end else begin
      eval_out_of_range = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge adc_clk) begin
    if (!rst_n) begin
      state      <= ST_SAMPLE;
      acc_max    <= '0;
      acc_min    <= '1;
      acc_cnt    <= '0;
      settle_cnt <= '0;
      stable_cnt <= '0;
      manual_q   <= 1'b0;
      gain_idx   <= RST_IDX;
      gain_ctrl  <= map_ctrl(RST_IDX);
      pp_value   <= '0;
      pp_valid   <= 1'b0;
      overload   <= 1'b0;
    end else begin
      pp_valid <= 1'b0;
      overload <= 1'b0;
      manual_q <= manual_en;

      if (manual_en) begin
        gain_idx   <= manual_clamped;
        gain_ctrl  <= map_ctrl(manual_clamped);
        stable_cnt <= '0;
      end

      if (manual_q && !manual_en) begin
        // Leaving manual mode: let the front end settle before trusting measurements again.
        state      <= ST_SETTLE;
        settle_cnt <= '0;
        stable_cnt <= '0;
        acc_max    <= '0;
        acc_min    <= '1;
        acc_cnt    <= '0;
      end else begin
        case (state)
          ST_SAMPLE: begin
            if (adc_valid) begin
              if (adc_data >= OVER_LVL) begin
                overload   <= 1'b1;
                stable_cnt <= '0;
                acc_max    <= '0;
                acc_min    <= '1;
                acc_cnt    <= '0;
                if (!manual_en && gain_idx != '0) begin
                  gain_idx   <= gain_idx - 1'b1;
                  gain_ctrl  <= map_ctrl(gain_idx - 1'b1);
                  settle_cnt <= '0;
                  state      <= ST_SETTLE;
                end
              end else begin
                if (adc_data > acc_max) acc_max <= adc_data;
                if (adc_data < acc_min) acc_min <= adc_data;
                acc_cnt <= acc_cnt + 1'b1;
                if (acc_cnt == LAST_CNT) state <= ST_CALC;
              end
            end
          end
          ST_CALC: begin
            pp_value <= acc_max - acc_min;
            pp_valid <= 1'b1;
            acc_max  <= '0;
            acc_min  <= '1;
            acc_cnt  <= '0;
            state    <= ST_EVAL;
          end
          ST_EVAL: begin
            state <= ST_SAMPLE;
            if (!manual_en) begin
              if (eval_target != gain_idx) begin
                gain_idx   <= eval_target;
                gain_ctrl  <= map_ctrl(eval_target);
                stable_cnt <= '0;
                settle_cnt <= '0;
                state      <= ST_SETTLE;
              end else if (eval_out_of_range) begin
                stable_cnt <= '0;
              end else if (stable_cnt != STB_MAX) begin
                stable_cnt <= stable_cnt + 1'b1;
              end
            end
          end
          ST_SETTLE: begin
            if (settle_cnt == SET_LAST) state <= ST_SAMPLE;
            else settle_cnt <= settle_cnt + 1'b1;
          end
          default: state <= ST_SAMPLE;
        endcase
      end
    end
  end

  assign stable = (stable_cnt == STB_MAX) && !manual_en;

endmodule

// File: tb/tb_agc_multistep.sv
// Bench for agc_multistep: table-driven windows, directed corner sequences, and a
// continuously running event-level reference model checked every cycle.
module tb_agc_multistep;

  localparam int DATA_W     = 12;
  localparam int IDX_W      = 2;
  localparam int CTRL_W     = 2;
  localparam int N_GAIN     = 4;
  localparam int WINDOW     = 512;
  localparam int SETTLE_CYC = 10;
  localparam int STABLE_W   = 3;
  localparam int OVER_TH    = 3941;
  localparam int LOWER [N_GAIN] = '{1791, 1791, 1791, 1798};
  localparam int UPPER [N_GAIN] = '{3685, 3883, 3723, 3883};
  localparam int GMAP  [N_GAIN] = '{0, 1, 2, 3};

  logic              adc_clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] adc_data;
  logic              adc_valid;
  logic              manual_en;
  logic [IDX_W-1:0]  manual_idx;
  logic [CTRL_W-1:0] gain_ctrl;
  logic [IDX_W-1:0]  gain_idx;
  logic              stable;
  logic [DATA_W-1:0] pp_value;
  logic              pp_valid;
  logic              overload;

  agc_multistep dut (
    .adc_clk    (adc_clk),
    .rst_n      (rst_n),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .manual_en  (manual_en),
    .manual_idx (manual_idx),
    .gain_ctrl  (gain_ctrl),
    .gain_idx   (gain_idx),
    .stable     (stable),
    .pp_value   (pp_value),
    .pp_valid   (pp_valid),
    .overload   (overload)
  );

  always #5 adc_clk = ~adc_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  // Reference model: a window is a queue of accepted samples; after it fills, the
  // result is published one edge later and judged the edge after that. "blind" counts
  // edges during which samples are discarded while the gain settles.
  int m_idx = 0, m_pp = 0, m_stable = 0;
  bit m_ppv = 0, m_ovl = 0;
  int win[$];
  int blind = 0, cyc = 0, pp_at = -1, dec_at = -1;
  bit man_prev = 0;
  int t_idx, lo_v, hi_v;
  bit bad;

  always @(posedge adc_clk) begin
    cyc++;
    m_ppv = 0;
    m_ovl = 0;
    if (!rst_n) begin
      m_idx = 0; m_pp = 0; m_stable = 0;
      win.delete();
      blind = 0; pp_at = -1; dec_at = -1; man_prev = 0;
    end else begin
      if (man_prev && !manual_en) begin
        win.delete();
        blind = SETTLE_CYC; pp_at = -1; dec_at = -1; m_stable = 0;
      end else begin
        if (manual_en) begin
          m_idx = (int'(manual_idx) > N_GAIN - 1) ? N_GAIN - 1 : int'(manual_idx);
          m_stable = 0;
        end
        if (cyc == pp_at) begin
          lo_v = 1 << DATA_W; hi_v = -1;
          foreach (win[i]) begin
            if (win[i] < lo_v) lo_v = win[i];
            if (win[i] > hi_v) hi_v = win[i];
          end
          m_pp = hi_v - lo_v;
          m_ppv = 1;
          win.delete();
        end else if (cyc == dec_at) begin
          if (!manual_en) begin
            t_idx = m_idx; bad = 1;
            if (m_pp > UPPER[m_idx])          t_idx = m_idx - 1;
            else if (m_pp < LOWER[m_idx] / 4) t_idx = m_idx + 2;
            else if (m_pp < LOWER[m_idx])     t_idx = m_idx + 1;
            else                              bad = 0;
            if (t_idx < 0) t_idx = 0;
            if (t_idx > N_GAIN - 1) t_idx = N_GAIN - 1;
            if (t_idx != m_idx) begin
              m_idx = t_idx; m_stable = 0; blind = SETTLE_CYC;
            end else if (bad) begin
              m_stable = 0;
            end else if (m_stable < STABLE_W) begin
              m_stable++;
            end
          end
        end else if (blind > 0) begin
          blind--;
        end else if (adc_valid) begin
          if (int'(adc_data) >= OVER_TH) begin
            m_ovl = 1; m_stable = 0;
            win.delete();
            if (!manual_en && m_idx > 0) begin
              m_idx--; blind = SETTLE_CYC;
            end
          end else begin
            win.push_back(int'(adc_data));
            if (win.size() == WINDOW) begin
              pp_at = cyc + 1; dec_at = cyc + 2;
            end
          end
        end
      end
      man_prev = manual_en;
    end
  end

  always @(negedge adc_clk) begin
    if (cyc > 0) begin
      check("mdl_gain_idx",  int'(gain_idx),  m_idx);
      check("mdl_gain_ctrl", int'(gain_ctrl), GMAP[m_idx]);
      check("mdl_stable",    int'(stable),    int'(m_stable == STABLE_W && !manual_en));
      check("mdl_pp_valid",  int'(pp_valid),  int'(m_ppv));
      check("mdl_pp_value",  int'(pp_value),  m_pp);
      check("mdl_overload",  int'(overload),  int'(m_ovl));
    end
  end

  // Idle long enough to clear any settle period, then toggle lo/hi until pp_valid,
  // then clock the judgement edge.
  task automatic run_window(input int lo, input int hi, output int pp, output bit seen);
    int k = 0;
    adc_valid = 1'b0;
    repeat (SETTLE_CYC + 2) tick();
    seen = 1'b0;
    pp = -1;
    for (int t = 0; t < 3000 && !seen; t++) begin
      adc_valid = 1'b1;
      adc_data  = DATA_W'((k % 2) ? hi : lo);
      k++;
      tick();
      if (pp_valid) begin
        seen = 1'b1;
        pp = int'(pp_value);
      end
    end
    adc_valid = 1'b0;
    tick();
  endtask

  typedef struct {
    int lo;
    int hi;
    int exp_pp;
    int exp_idx;
    bit exp_stable;
  } win_vec_t;

  win_vec_t vecs[19];
  int       pp_got, cnt, span_base, span_w;
  bit       seen;

  initial begin
    vecs[0]  = '{500, 3000, 2500, 0, 1'b0};
    vecs[1]  = '{500, 3000, 2500, 0, 1'b0};
    vecs[2]  = '{500, 3000, 2500, 0, 1'b1};
    vecs[3]  = '{1000, 1300, 300, 2, 1'b0};
    vecs[4]  = '{1000, 2000, 1000, 3, 1'b0};
    vecs[5]  = '{0, 3900, 3900, 2, 1'b0};
    vecs[6]  = '{0, 3800, 3800, 1, 1'b0};
    vecs[7]  = '{1000, 1100, 100, 3, 1'b0};
    vecs[8]  = '{1000, 2500, 1500, 3, 1'b0};
    vecs[9]  = '{500, 3500, 3000, 3, 1'b0};
    vecs[10] = '{0, 3900, 3900, 2, 1'b0};
    vecs[11] = '{0, 3900, 3900, 1, 1'b0};
    vecs[12] = '{0, 3900, 3900, 0, 1'b0};
    vecs[13] = '{0, 3900, 3900, 0, 1'b0};
    vecs[14] = '{0, 3685, 3685, 0, 1'b0};
    vecs[15] = '{0, 1791, 1791, 0, 1'b0};
    vecs[16] = '{100, 547, 447, 1, 1'b0};
    vecs[17] = '{100, 546, 446, 3, 1'b0};
    vecs[18] = '{0, 3900, 3900, 2, 1'b0};

    rst_n = 1'b0; adc_data = '0; adc_valid = 1'b0; manual_en = 1'b0; manual_idx = '0;
    repeat (3) tick();
    check("rst_gain_idx",  int'(gain_idx),  0);
    check("rst_gain_ctrl", int'(gain_ctrl), 0);
    check("rst_stable",    int'(stable),    0);
    check("rst_pp_value",  int'(pp_value),  0);
    check("rst_pp_valid",  int'(pp_valid),  0);
    check("rst_overload",  int'(overload),  0);
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      run_window(vecs[v].lo, vecs[v].hi, pp_got, seen);
      check($sformatf("vec%0d_pp_seen", v),  int'(seen),      1);
      check($sformatf("vec%0d_pp_value", v), pp_got,          vecs[v].exp_pp);
      check($sformatf("vec%0d_gain_idx", v), int'(gain_idx),  vecs[v].exp_idx);
      check($sformatf("vec%0d_gain_ctrl", v), int'(gain_ctrl), GMAP[vecs[v].exp_idx]);
      check($sformatf("vec%0d_stable", v),   int'(stable),    int'(vecs[v].exp_stable));
    end

    // Overload on sample 100 of a fresh window at idx2.
    adc_valid = 1'b0;
    repeat (SETTLE_CYC + 2) tick();
    for (int i = 0; i < 100; i++) begin
      adc_valid = 1'b1;
      adc_data  = (i % 2) ? 12'd2000 : 12'd1000;
      tick();
    end
    adc_data = 12'd4000;
    tick();
    check("ovl_pulse",     int'(overload),  1);
    check("ovl_gain_idx",  int'(gain_idx),  1);
    check("ovl_gain_ctrl", int'(gain_ctrl), 1);
    check("ovl_stable",    int'(stable),    0);
    check("ovl_no_pp",     int'(pp_valid),  0);
    adc_data = 12'd1000;
    tick();
    check("ovl_one_cycle", int'(overload), 0);
    cnt = 0;
    for (int i = 0; i < 420; i++) begin
      adc_data = (i % 2) ? 12'd2000 : 12'd1000;
      tick();
      if (pp_valid) cnt++;
    end
    check("ovl_window_aborted", cnt, 0);

    // 50% valid duty, reset at valid sample 300, then a full fresh window.
    for (int i = 0; i < 600; i++) begin
      adc_valid = (i % 2 == 0);
      adc_data  = ((i / 2) % 2) ? 12'd3000 : 12'd600;
      tick();
    end
    rst_n = 1'b0;
    tick();
    check("midrst_gain_idx",  int'(gain_idx),  0);
    check("midrst_gain_ctrl", int'(gain_ctrl), 0);
    check("midrst_stable",    int'(stable),    0);
    check("midrst_pp_value",  int'(pp_value),  0);
    check("midrst_pp_valid",  int'(pp_valid),  0);
    check("midrst_overload",  int'(overload),  0);
    rst_n = 1'b1;
    cnt = 0; seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      adc_valid = (i % 2 == 0);
      adc_data  = ((i / 2) % 2) ? 12'd3000 : 12'd600;
      tick();
      if (pp_valid) seen = 1'b1;
      else if (adc_valid) cnt++;
    end
    check("midrst_pp_seen",       int'(seen),     1);
    check("midrst_valid_samples", cnt,            WINDOW);
    check("midrst_pp_value",      int'(pp_value), 2400);
    adc_valid = 1'b0;
    tick();

    // Limit reached at idx0: no settle, next window starts right after the judgement edge.
    run_window(0, 3900, pp_got, seen);
    check("limit_gain_idx", int'(gain_idx), 0);
    check("limit_stable",   int'(stable),   0);
    cnt = 0; seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      adc_valid = 1'b1;
      adc_data  = (i % 2) ? 12'd3000 : 12'd500;
      tick();
      cnt++;
      if (pp_valid) seen = 1'b1;
    end
    check("limit_next_window_ticks", cnt, WINDOW + 1);
    adc_valid = 1'b0;
    tick();

    // Manual override, then release into automatic control from idx3.
    manual_en = 1'b1; manual_idx = 2'd3;
    tick();
    check("man_gain_idx",  int'(gain_idx),  3);
    check("man_gain_ctrl", int'(gain_ctrl), 3);
    check("man_stable",    int'(stable),    0);
    run_window(0, 3900, pp_got, seen);
    check("man_pp_seen",   int'(seen),     1);
    check("man_pp_value",  pp_got,         3900);
    check("man_hold_idx",  int'(gain_idx), 3);
    run_window(500, 3000, pp_got, seen);
    check("man_pp2_value", pp_got,         2500);
    check("man_stable2",   int'(stable),   0);
    manual_en = 1'b0;
    cnt = 0; seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      adc_valid = 1'b1;
      adc_data  = (i % 2) ? 12'd3900 : 12'd0;
      tick();
      cnt++;
      if (pp_valid) seen = 1'b1;
    end
    check("man_release_ticks", cnt, SETTLE_CYC + WINDOW + 2);
    check("man_release_pp",    int'(pp_value), 3900);
    adc_valid = 1'b0;
    tick();
    check("man_release_auto_idx", int'(gain_idx), 2);

    // Randomised traffic, judged by the model alone.
    for (int blk = 0; blk < 10; blk++) begin
      span_base = int'($urandom_range(0, 2000));
      span_w    = int'($urandom_range(0, 1900));
      for (int i = 0; i < 900; i++) begin
        adc_valid = ($urandom_range(0, 3) != 0);
        adc_data  = DATA_W'(span_base + int'($urandom_range(0, span_w)));
        if ($urandom_range(0, 1999) == 0) adc_data = 12'd4000;
        if ($urandom_range(0, 1499) == 0) manual_en = ~manual_en;
        manual_idx = IDX_W'($urandom_range(0, 3));
        rst_n = ($urandom_range(0, 4999) != 0);
        tick();
      end
    end
    rst_n = 1'b1; manual_en = 1'b0; adc_valid = 1'b0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/agc_multistep.md
# agc_multistep

Parametrised automatic gain controller for the ADC front end, sitting between the ADC capture path and the programmable-gain relay/switch driver. It replaces the fixed 12-bit / 4-step controller with configurable sample width, gain-step count, window length and threshold tables. It adds a sample-valid qualifier, coarse two-step gain jumps, a manual override mode and exported peak-to-peak measurements.

## Interface
- DATA_W, 12: ADC sample width.
- N_GAIN, 4: number of gain steps. Index 0 is the lowest gain; N_GAIN-1 is the highest. IDX_W = max(1, clog2(N_GAIN)).
- CTRL_W, 2: width of the relay control word.
- GAIN_MAP, {2'd3,2'd2,2'd1,2'd0}: packed N_GAIN*CTRL_W. Entry i at [i*CTRL_W +: CTRL_W] is the control word for index i.
- LOWER_TH, {1798,1791,1791,1791}: packed N_GAIN*DATA_W. Per-index minimum acceptable peak-to-peak value.
- UPPER_TH, {3883,3723,3883,3685}: packed N_GAIN*DATA_W. Per-index maximum acceptable peak-to-peak value.
- OVER_TH, 3941: instantaneous overload threshold.
- WINDOW, 512: valid samples per measurement window (≥2).
- SETTLE_CYCLES, 10: clock cycles ignored after any gain change.
- STABLE_WINDOWS, 3: consecutive in-range windows required before stable is asserted.
- INIT_IDX, 0: gain index after reset.

Ports:
- adc_clk  in  1  sample clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- adc_data  in  DATA_W  unsigned ADC sample.
- adc_valid  in  1  sample qualifier; samples with adc_valid=0 are ignored.
- manual_en  in  1  1 = manual gain mode.
- manual_idx  in  IDX_W  requested index in manual mode; values above N_GAIN-1 clamp to N_GAIN-1.
- gain_ctrl  out  CTRL_W  registered GAIN_MAP[gain_idx].
- gain_idx  out  IDX_W  current gain index.
- stable  out  1  signal in range for STABLE_WINDOWS windows.
- pp_value  out  DATA_W  last window peak-to-peak (max−min).
- pp_valid  out  1  one-cycle pulse when pp_value updates.
- overload  out  1  one-cycle pulse on overload detection.

## Operation
- States are SAMPLE, CALC, EVAL and SETTLE. Reset enters SAMPLE with max=0, min=all-ones and count=0.
- **SAMPLE:** on each adc_valid, update max/min and increment count.
  - On the WINDOW-th valid sample, go to CALC.
  - If a valid sample is ≥ OVER_TH, abort the window and pulse overload. Then:
    - if gain_idx>0, decrement it and go to SETTLE;
    - otherwise clear max/min/count and stay in SAMPLE.
  - Any overload also clears stable_cnt.
  - Overload takes priority over window completion when both occur on the same sample.
- **CALC:** register pp_value = max−min (unsigned, DATA_W bits, no underflow possible). Clear max/min/count. Go to EVAL.
  - pp_valid pulses in the EVAL cycle.
- **EVAL:** compare pp_value against LOWER_TH/UPPER_TH[gain_idx].
  - pp > UPPER: target = idx−1.
  - pp < (LOWER>>2): target = idx+2.
  - Otherwise pp < LOWER: target = idx+1.
  - Target clamps to [0, N_GAIN-1].
  - If the clamped target differs from idx: load gain_idx and gain_ctrl, clear stable_cnt, go to SETTLE.
  - If out of range but clamped to idx (limit reached): clear stable_cnt, go to SAMPLE, no gain change.
  - If in range: stable_cnt saturates up to STABLE_WINDOWS, go to SAMPLE.
- **SETTLE:** count SETTLE_CYCLES clocks, ignoring all samples, then go to SAMPLE with a fresh window.
- **Manual mode (manual_en=1):**
  - gain_idx/gain_ctrl follow the clamped manual_idx, registered at 1-cycle latency.
  - Automatic decisions and overload-driven decrements are suppressed. Windows are still measured and pp_valid still pulses, and overload still pulses.
  - stable=0 and stable_cnt is held at 0.
  - When manual_en falls, go to SETTLE (stable_cnt=0), then resume automatic operation from the manual index.
- stable = (stable_cnt == STABLE_WINDOWS) && !manual_en.

## Timing
- Reset values: gain_idx=INIT_IDX, gain_ctrl=GAIN_MAP[INIT_IDX], stable=0, pp_value=0, pp_valid=0, overload=0. The state machine is in SAMPLE with empty accumulators.
- rst_n is sampled only on an adc_clk edge. If it is asserted mid-window, mid-settle or in manual mode, all state returns to reset values at that edge.
- Window completion latency:
  - edge E accepts the last sample;
  - state=CALC during E+1;
  - pp_valid=1 and pp_value are updated in the cycle after E+1;
  - gain_ctrl changes at the following edge.
- Overload sample accepted at edge E: overload=1 and gain_ctrl updated in the cycle after E.
- The first sample considered after SETTLE is the one presented in the first SAMPLE cycle, which comes SETTLE_CYCLES cycles after entering SETTLE.
- No input handshake: adc_valid is a qualifier only, and gaps extend the window.

## Test plan
- Defaults; a 2500-count peak-to-peak ramp at idx0 for 3 windows -> three pp_valid pulses with pp_value=2500, gain_ctrl=2'b00, stable=1 after the third pulse.
- idx0 with a 300-count peak-to-peak window (<1791>>2=447) -> gain_idx=2, gain_ctrl=2'b10, SETTLE for 10 cycles. A 1000-count window then gives idx3.
- idx2, single sample 4000 at sample 100 of the window -> overload pulse, gain_idx=1, no pp_valid for that window, stable=0.
- idx0 with a 3900-count peak-to-peak window -> gain_idx stays 0, stable_cnt cleared, no SETTLE (next window starts immediately).
- manual_en=1, manual_idx=3 -> gain_ctrl=2'b11 one cycle later, stable=0, pp_valid still pulsing every 512 valid samples. manual_en=0 -> 10 settle cycles, then auto control from idx3.
- adc_valid toggling 50%, with rst_n pulsed low for one cycle at sample 300 -> all outputs at reset values. The next pp_valid arrives only after 512 further valid samples.
